ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single RAM port among NREQ cache requesters
//  (e.g. cpu0 I$, cpu0 D$, cpu1 I$, cpu1 D$). Registers a grant, holds it until
//  the RAM completes (ACCESS), then rotates priority. A watchdog releases a stuck
//  grant. Sits between the per-CPU cache ports and the RAM, under memory control.
// PARAMETERS
//  NREQ     4    number of requesters (2..8)
//  TIMEOUT  64   max cycles a grant may wait for ACCESS before forced release
// PORTS
//  CLK          in   1          clock, rising edge
//  nRST         in   1          reset, asynchronous, active-low
//  req_ren      in   NREQ       per-requester read request
//  req_wen      in   NREQ       per-requester write request
//  req_addr     in   NREQ*32    per-requester word address, requester i at [32i+31:32i]
//  req_store    in   NREQ*32    per-requester write data, same packing
//  req_wait     out  NREQ       per-requester wait; 0 only on completion cycle
//  req_load     out  32         RAM read data, broadcast to all requesters
//  ramREN       out  1          RAM read enable
//  ramWEN       out  1          RAM write enable
//  ramaddr      out  32         RAM address
//  ramstore     out  32         RAM write data
//  ramload      in   32         RAM read data
//  ramstate     in   2          ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3
//  owner        out  3          index of current grant holder (valid when grant_vld)
//  grant_vld    out  1          a grant is held
//  timeout      out  1          one-cycle pulse on watchdog release
// BEHAVIOUR
//  Reset (async, nRST=0): state=IDLE, ptr=0, owner=0, wdog=0; grant_vld=0,
//   ramREN=ramWEN=0, ramaddr=ramstore=0, req_wait all 1, timeout=0.
//  req_i = req_ren[i] | req_wen[i]. If both are set, write wins (ramREN=0).
//  FSM states:
//   IDLE:  if any req_i, winner = first requesting index scanning ptr, ptr+1, ...
//          (mod NREQ); register owner<=winner, go GRANT next cycle. Else stay.
//   GRANT: ramaddr/ramstore muxed from req_addr/req_store[owner]; ramWEN=req_wen[owner];
//          ramREN=req_ren[owner]&~req_wen[owner]. wdog increments each cycle.
//          ramstate==ACCESS: req_wait[owner]=0 this cycle (combinational); next
//            cycle IDLE, ptr<=owner+1 (wraps NREQ-1 -> 0), wdog<=0.
//          req_owner deasserted (abort): enables drop same cycle, next cycle IDLE,
//            ptr<=owner+1; no completion reported.
//          wdog==TIMEOUT-1 without ACCESS: next cycle IDLE, ptr<=owner+1,
//            timeout pulses 1 for that one cycle; requester still waiting re-arbitrates.
//          BUSY, FREE, ERROR: hold grant, all waits stay 1 (ERROR is retried).
//  In IDLE, ramREN=ramWEN=0 and all req_wait=1. Non-owners see req_wait=1 always.
//  Latency: request in IDLE at cycle t -> RAM enables at t+1; completion cycle is
//   first ACCESS cycle >= t+1; one IDLE bubble between consecutive grants.
//  Fairness: a continuously requesting requester is served within NREQ grants.
//  Requests arriving during GRANT are not sampled until the next IDLE.
//  ACCESS with ACCESS completion and abort in same cycle: abort wins, no completion.
//  Reset mid-GRANT: enables drop immediately (async), state returns to IDLE.
// TESTING
//  1 Single read: req_ren[2]=1, addr 0x40, RAM ACCESS 2 cycles later, ramload=0xDEADBEEF
//    -> owner=2, ramREN=1, ramaddr=0x40, req_wait[2]=0 one cycle, req_load=0xDEADBEEF.
//  2 All four request reads continuously from reset -> grant order 0,1,2,3,0, one IDLE
//    bubble between grants, no requester skipped.
//  3 req_ren[1]=req_wen[1]=1, store 0x1234 -> ramWEN=1, ramREN=0, ramstore=0x1234.
//  4 Grant to 3, ramstate held BUSY 64 cycles (TIMEOUT=64) -> timeout pulse on
//    cycle 64, IDLE, ptr=0, requester 3 re-granted only after 0..2 if requesting.
//  5 Owner 1 drops req_ren mid-GRANT while BUSY -> ramREN=0 same cycle, IDLE next,
//    req_wait[1] never 0, ptr=2.
//  6 nRST pulsed low during GRANT with ramWEN=1 -> ramWEN=0 immediately, all waits 1,
//    grant_vld=0, ptr=0 after release.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Round-robin arbiter that shares one RAM port among NREQ cache requesters.
// A winner is picked in IDLE, scanning from the rotating priority pointer. The
// grant is registered and held until the RAM reports ACCESS, the owner drops
// its request, or the watchdog expires. Priority then rotates past the owner.
//
// Ports
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   req_ren / req_wen    per-requester read / write request (write wins)
//   req_addr / req_store per-requester address / write data, 32 bits each,
//                        requester i at [32i+31:32i]
//   req_wait             per-requester wait, low only on the owner's completion
//   req_load             RAM read data broadcast to every requester
//   ramREN/ramWEN/ramaddr/ramstore  RAM-side request
//   ramload / ramstate   RAM-side response (FREE, BUSY, ACCESS, ERROR)
//   owner / grant_vld    current grant holder and grant-held flag
//   timeout              one-cycle pulse when the watchdog releases a grant
module ram_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [NREQ-1:0]    req_ren,
  input  logic [NREQ-1:0]    req_wen,
  input  logic [NREQ*32-1:0] req_addr,
  input  logic [NREQ*32-1:0] req_store,
  output logic [NREQ-1:0]    req_wait,
  output logic [31:0]        req_load,
  output logic               ramREN,
  output logic               ramWEN,
  output logic [31:0]        ramaddr,
  output logic [31:0]        ramstore,
  input  logic [31:0]        ramload,
  input  logic [1:0]         ramstate,
  output logic [2:0]         owner,
  output logic               grant_vld,
  output logic               timeout
);

  localparam int WDW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [2:0]     ptr_q, ptr_d;
  logic [2:0]     owner_q, owner_d;
  logic [WDW-1:0] wdog_q, wdog_d;

  // Request vectors padded to 8 so a 3-bit index is always in range.
  logic [7:0] ren_pad, wen_pad, req_pad;
  logic       found;
  logic [2:0] winner;
  logic [2:0] owner_next;
  logic       own_ren, own_wen, own_req;

  always_comb begin
    ren_pad = '0;
    wen_pad = '0;
    ren_pad[NREQ-1:0] = req_ren;
    wen_pad[NREQ-1:0] = req_wen;
    req_pad = ren_pad | wen_pad;
    own_ren = ren_pad[owner_q];
    own_wen = wen_pad[owner_q];
    own_req = req_pad[owner_q];
  end

  // Round-robin scan starting at ptr_q, wrapping modulo NREQ.
  always_comb begin
    logic [3:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + 4'(k);
      if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
      if (!found && req_pad[idx[2:0]]) begin
        found  = 1'b1;
        winner = idx[2:0];
      end
    end
  end

  // Priority pointer after releasing the current owner.
  always_comb begin
    if (owner_q == 3'(NREQ - 1)) owner_next = '0;
    else                         owner_next = owner_q + 3'd1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      wdog_q  <= wdog_d;
    end
  end

  // Release priority: abort beats completion, completion beats the watchdog.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    wdog_d    = wdog_q;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    req_wait  = '1;
    timeout   = 1'b0;
    grant_vld = 1'b0;
    case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (found) begin
          owner_d = winner;
          state_d = GRANT;
        end
      end
      GRANT: begin
        grant_vld = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
          if (owner_q == 3'(i)) begin
            ramaddr  = req_addr[i*32 +: 32];
            ramstore = req_store[i*32 +: 32];
          end
        end
        if (!own_req) begin
          state_d = IDLE;
          ptr_d   = owner_next;
          wdog_d  = '0;
        end else begin
          ramWEN = own_wen;
          ramREN = own_ren & ~own_wen;
          if (ramstate == ACCESS) begin
            for (int i = 0; i < NREQ; i++) begin
              if (owner_q == 3'(i)) req_wait[i] = 1'b0;
            end
            state_d = IDLE;
            ptr_d   = owner_next;
            wdog_d  = '0;
          end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
            timeout = 1'b1;
            state_d = IDLE;
            ptr_d   = owner_next;
            wdog_d  = '0;
          end else begin
            wdog_d = wdog_q + WDW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_load  = ramload;
  assign owner     = owner_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed bench for ram_arbiter (NREQ=4, TIMEOUT=64). One linear sequence of
// steps covers reset, round-robin order, single read, write priority, abort,
// watchdog release and asynchronous reset during a grant.
module tb_ram_arbiter;

  logic         CLK;
  logic         nRST;
  logic [3:0]   req_ren;
  logic [3:0]   req_wen;
  logic [127:0] req_addr;
  logic [127:0] req_store;
  logic [3:0]   req_wait;
  logic [31:0]  req_load;
  logic         ramREN;
  logic         ramWEN;
  logic [31:0]  ramaddr;
  logic [31:0]  ramstore;
  logic [31:0]  ramload;
  logic [1:0]   ramstate;
  logic [2:0]   owner;
  logic         grant_vld;
  logic         timeout;

  int passCount  = 0;
  int checkCount = 0;

  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;

  ram_arbiter #(.NREQ(4), .TIMEOUT(64)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_ren(req_ren), .req_wen(req_wen),
    .req_addr(req_addr), .req_store(req_store),
    .req_wait(req_wait), .req_load(req_load),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .owner(owner), .grant_vld(grant_vld), .timeout(timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input int idx, input logic ren, input logic wen,
                               input logic [31:0] addr, input logic [31:0] store);
    req_ren[idx] = ren;
    req_wen[idx] = wen;
    req_addr[idx*32 +: 32]  = addr;
    req_store[idx*32 +: 32] = store;
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  // Called in an IDLE cycle with requests already applied; serves one read
  // grant that completes on its first grant cycle and returns in IDLE.
  task automatic serveRead(input int expOwner, input logic [31:0] expAddr);
    logic [3:0] expWait;
    expWait = 4'hF;
    expWait[expOwner] = 1'b0;
    #1;
    checkOutput("bubble_vld", 32'(grant_vld), 32'd0);
    nextCycle();
    checkOutput($sformatf("owner_%0d", expOwner), 32'(owner), 32'(expOwner));
    checkOutput("grant_ren", 32'(ramREN), 32'd1);
    checkOutput("grant_addr", ramaddr, expAddr);
    ramstate = RS_ACCESS;
    #1;
    checkOutput("done_wait", 32'(req_wait), 32'(expWait));
    nextCycle();
    ramstate = RS_BUSY;
  endtask

  initial begin
    nRST = 1'b0;
    req_ren = '0;
    req_wen = '0;
    req_addr = '0;
    req_store = '0;
    ramload = '0;
    ramstate = RS_BUSY;
    #3;
    checkOutput("rst_vld", 32'(grant_vld), 32'd0);
    checkOutput("rst_owner", 32'(owner), 32'd0);
    checkOutput("rst_wait", 32'(req_wait), 32'hF);
    checkOutput("rst_en", {30'd0, ramREN, ramWEN}, 32'd0);
    checkOutput("rst_addr", ramaddr, 32'd0);
    checkOutput("rst_timeout", 32'(timeout), 32'd0);
    nextCycle();
    nextCycle();
    nRST = 1'b1;
    nextCycle();

    $display("[TB] round-robin from reset");
    for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1, 1'b0, 32'h100 * i + 32'h10, 32'd0);
    serveRead(0, 32'h010);
    serveRead(1, 32'h110);
    serveRead(2, 32'h210);
    serveRead(3, 32'h310);
    serveRead(0, 32'h010);
    req_ren = '0;

    $display("[TB] single read");
    applyStimulus(2, 1'b1, 1'b0, 32'h40, 32'd0);
    #1;
    checkOutput("t1_idle_wait", 32'(req_wait), 32'hF);
    nextCycle();
    checkOutput("t1_owner", 32'(owner), 32'd2);
    checkOutput("t1_ren", 32'(ramREN), 32'd1);
    checkOutput("t1_addr", ramaddr, 32'h40);
    checkOutput("t1_busy_wait", 32'(req_wait), 32'hF);
    nextCycle();
    ramstate = RS_ACCESS;
    ramload = 32'hDEADBEEF;
    #1;
    checkOutput("t1_wait", 32'(req_wait), 32'hB);
    checkOutput("t1_load", req_load, 32'hDEADBEEF);
    nextCycle();
    ramstate = RS_BUSY;
    req_ren = '0;
    #1;
    checkOutput("t1_idle_vld", 32'(grant_vld), 32'd0);
    checkOutput("t1_idle_ren", 32'(ramREN), 32'd0);

    $display("[TB] write wins over read");
    applyStimulus(1, 1'b1, 1'b1, 32'h80, 32'h1234);
    nextCycle();
    checkOutput("t3_owner", 32'(owner), 32'd1);
    checkOutput("t3_wen", 32'(ramWEN), 32'd1);
    checkOutput("t3_ren", 32'(ramREN), 32'd0);
    checkOutput("t3_store", ramstore, 32'h1234);
    ramstate = RS_ACCESS;
    #1;
    checkOutput("t3_wait", 32'(req_wait), 32'hD);
    nextCycle();
    ramstate = RS_BUSY;
    req_ren = '0;
    req_wen = '0;

    $display("[TB] owner abort");
    applyStimulus(1, 1'b1, 1'b0, 32'h90, 32'd0);
    nextCycle();
    checkOutput("t5_owner", 32'(owner), 32'd1);
    checkOutput("t5_ren_on", 32'(ramREN), 32'd1);
    req_ren[1] = 1'b0;
    ramstate = RS_ACCESS;
    #1;
    checkOutput("t5_ren_drop", 32'(ramREN), 32'd0);
    checkOutput("t5_wait", 32'(req_wait), 32'hF);
    nextCycle();
    ramstate = RS_BUSY;
    #1;
    checkOutput("t5_idle_vld", 32'(grant_vld), 32'd0);
    applyStimulus(1, 1'b1, 1'b0, 32'h90, 32'd0);
    applyStimulus(2, 1'b1, 1'b0, 32'hA0, 32'd0);
    serveRead(2, 32'hA0);
    req_ren = '0;

    $display("[TB] watchdog release");
    applyStimulus(3, 1'b1, 1'b0, 32'hB0, 32'd0);
    nextCycle();
    checkOutput("t4_owner", 32'(owner), 32'd3);
    for (int c = 1; c <= 64; c++) begin
      checkOutput($sformatf("t4_timeout_c%0d", c), 32'(timeout), (c == 64) ? 32'd1 : 32'd0);
      if (c < 64) nextCycle();
    end
    for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, 1'b0, 32'h100 * i + 32'h10, 32'd0);
    nextCycle();
    checkOutput("t4_idle_vld", 32'(grant_vld), 32'd0);
    checkOutput("t4_idle_timeout", 32'(timeout), 32'd0);
    serveRead(0, 32'h010);
    serveRead(1, 32'h110);
    serveRead(2, 32'h210);
    serveRead(3, 32'hB0);
    req_ren = '0;

    $display("[TB] reset during grant");
    applyStimulus(2, 1'b0, 1'b1, 32'hC0, 32'hCAFE);
    nextCycle();
    checkOutput("t6_wen_on", 32'(ramWEN), 32'd1);
    checkOutput("t6_owner", 32'(owner), 32'd2);
    nRST = 1'b0;
    #1;
    checkOutput("t6_wen_drop", 32'(ramWEN), 32'd0);
    checkOutput("t6_vld", 32'(grant_vld), 32'd0);
    checkOutput("t6_wait", 32'(req_wait), 32'hF);
    checkOutput("t6_owner_rst", 32'(owner), 32'd0);
    req_wen = '0;
    applyStimulus(1, 1'b1, 1'b0, 32'hD0, 32'd0);
    applyStimulus(3, 1'b1, 1'b0, 32'hE0, 32'd0);
    nextCycle();
    nRST = 1'b1;
    serveRead(1, 32'hD0);
    req_ren = '0;
    nextCycle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
